// File: rtl/pc_pkg.sv
// Shared types, condition codes and sizing helper for the program-counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_REDIRECT,
    PC_HOLD,
    PC_RET_RAS,
    PC_RET_RA,
    PC_CALL,
    PC_JUMP,
    PC_SEQ
  } pc_sel_t;

  // jmpcond[2:0] selects the predicate; jmpcond[3] marks a return.
  localparam logic [2:0] CC_AL = 3'd0;
  localparam logic [2:0] CC_EQ = 3'd1;
  localparam logic [2:0] CC_NE = 3'd2;
  localparam logic [2:0] CC_CS = 3'd3;
  localparam logic [2:0] CC_CC = 3'd4;
  localparam logic [2:0] CC_MI = 3'd5;
  localparam logic [2:0] CC_VS = 3'd6;
  localparam logic [2:0] CC_NV = 3'd7;

  function automatic int unsigned ras_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cond.sv
// Condition evaluator: turns ALU flags and a condition code into jump/return qualifiers.
module cond
  import pc_pkg::*;
(
  input  logic       flagn,
  input  logic       flagz,
  input  logic       flagc,
  input  logic       flagv,
  input  logic [3:0] jmpcond,
  output logic       cond_jmp,
  output logic       cond_ret
);

  logic pred;

  always_comb begin
    pred = 1'b0;
    case (jmpcond[2:0])
      CC_AL:   pred = 1'b1;
      CC_EQ:   pred = flagz;
      CC_NE:   pred = ~flagz;
      CC_CS:   pred = flagc;
      CC_CC:   pred = ~flagc;
      CC_MI:   pred = flagn;
      CC_VS:   pred = flagv;
      CC_NV:   pred = 1'b0;
      default: pred = 1'b0;
    endcase
  end

  assign cond_jmp = pred & ~jmpcond[3];
  assign cond_ret = pred &  jmpcond[3];

endmodule

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [REG_WIDTH-1:0]       push_data,
  output logic [REG_WIDTH-1:0]       top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned PW = ras_ptr_w(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic [REG_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]        sp_q, sp_d;
  logic [CW-1:0]        count_q, count_d;

  assign full  = (count_q == CW'(RAS_DEPTH));
  assign empty = (count_q == '0);
  assign ovf   = push & full;
  assign unf   = pop & empty;
  assign top   = mem_q[sp_q - PW'(1)];
  assign count = count_q;

  // Push has precedence; the caller never issues both in one cycle.
  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    if (push) begin
      sp_d = sp_q + PW'(1);
      if (!full) count_d = count_q + CW'(1);
    end else if (pop && !empty) begin
      sp_d    = sp_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[sp_q] <= push_data;
  end

endmodule

// File: rtl/pc_seq.sv
// Registered program counter with call/return stack, stall, redirect and sticky stack error.
module pc_seq
  import pc_pkg::*;
#(
  parameter int unsigned    REG_WIDTH = 16,
  parameter int unsigned    RAS_DEPTH = 4,
  parameter logic [REG_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [REG_WIDTH-1:0]       redirect_pc,
  input  logic                       flagn,
  input  logic                       flagz,
  input  logic                       flagc,
  input  logic                       flagv,
  input  logic [3:0]                 jmpcond,
  input  logic                       jmp,
  input  logic                       call,
  input  logic [REG_WIDTH-1:0]       offset,
  input  logic [REG_WIDTH-1:0]       ra,
  output logic [REG_WIDTH-1:0]       pc,
  output logic [REG_WIDTH-1:0]       pcnext,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_err
);

  logic [REG_WIDTH-1:0] pc_q, pc_d;
  logic                 err_q, err_d;
  logic                 cond_jmp, cond_ret;
  logic [REG_WIDTH-1:0] pc_inc, pc_off, ras_top;
  logic                 ras_push, ras_pop, ras_ovf, ras_unf;
  pc_sel_t              flow_sel, sel;

  cond u_cond (
    .flagn    (flagn),
    .flagz    (flagz),
    .flagc    (flagc),
    .flagv    (flagv),
    .jmpcond  (jmpcond),
    .cond_jmp (cond_jmp),
    .cond_ret (cond_ret)
  );

  ras_stack #(
    .REG_WIDTH (REG_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

  assign pc_inc = pc_q + REG_WIDTH'(1);
  assign pc_off = pc_q + offset;

  // Control-flow choice ignoring stall; pcnext is derived from this.
  always_comb begin
    flow_sel = PC_SEQ;
    if (redirect)                    flow_sel = PC_REDIRECT;
    else if (jmp && cond_ret)        flow_sel = ras_empty ? PC_RET_RA : PC_RET_RAS;
    else if (jmp && call && cond_jmp) flow_sel = PC_CALL;
    else if (jmp && cond_jmp)        flow_sel = PC_JUMP;
  end

  always_comb begin
    pcnext = pc_inc;
    case (flow_sel)
      PC_REDIRECT: pcnext = redirect_pc;
      PC_RET_RAS:  pcnext = ras_top;
      PC_RET_RA:   pcnext = ra;
      PC_CALL:     pcnext = pc_off;
      PC_JUMP:     pcnext = pc_off;
      default:     pcnext = pc_inc;
    endcase
  end

  assign sel      = (stall && flow_sel != PC_REDIRECT) ? PC_HOLD : flow_sel;
  assign ras_push = (sel == PC_CALL);
  // A return on an empty stack pops too so the stack reports underflow.
  assign ras_pop  = (sel == PC_RET_RAS) || (sel == PC_RET_RA);

  always_comb begin
    pc_d  = (sel == PC_HOLD) ? pc_q : pcnext;
    err_d = err_q | ras_ovf | ras_unf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc      = pc_q;
  assign ras_err = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq with REG_WIDTH=16, RAS_DEPTH=4, RESET_PC=0.
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, flagn, flagz, flagc, flagv, jmp, call;
  logic [15:0] redirect_pc, offset, ra;
  logic [3:0]  jmpcond;
  logic [15:0] pc, pcnext;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_err;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] C_AL  = 4'h0;
  localparam logic [3:0] C_EQ  = 4'h1;
  localparam logic [3:0] C_NV  = 4'h7;
  localparam logic [3:0] C_RET = 4'h8;

  pc_seq #(.REG_WIDTH(16), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .flagn(flagn), .flagz(flagz), .flagc(flagc),
    .flagv(flagv), .jmpcond(jmpcond), .jmp(jmp), .call(call), .offset(offset),
    .ra(ra), .pc(pc), .pcnext(pcnext), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    stall = 0; redirect = 0; redirect_pc = '0; jmp = 0; call = 0;
    jmpcond = C_AL; offset = '0; ra = '0;
    flagn = 0; flagz = 0; flagc = 0; flagv = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [15:0] target);
    idle(); redirect = 1; redirect_pc = target;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #3;
    checks++;
    if (pc !== 16'h0000 || ras_count !== 3'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h cnt=%0d empty=%b full=%b err=%b, expected pc=0000 cnt=0 empty=1 full=0 err=0",
               pc, ras_count, ras_empty, ras_full, ras_err);
    end
    #9 rst_n = 1;
  endtask

  task automatic test_seq();
    logic [15:0] exp_pc [3] = '{16'h0001, 16'h0002, 16'h0003};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== exp_pc[i] || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
        errors++;
        $display("FAIL seq[%0d]: pc=%h empty=%b err=%b, expected pc=%h empty=1 err=0",
                 i, pc, ras_empty, ras_err, exp_pc[i]);
      end
    end
  endtask

  task automatic test_call_ret();
    go_to(16'h0010);
    jmp = 1; call = 1; jmpcond = C_AL; offset = 16'h0020;
    #1;
    checks++;
    if (pcnext !== 16'h0030) begin
      errors++;
      $display("FAIL call_pcnext: got %h expected 0030", pcnext);
    end
    tick();
    checks++;
    if (pc !== 16'h0030 || ras_count !== 3'd1) begin
      errors++;
      $display("FAIL call: pc=%h cnt=%0d, expected pc=0030 cnt=1", pc, ras_count);
    end
    idle(); jmp = 1; jmpcond = C_RET;
    tick();
    checks++;
    if (pc !== 16'h0011 || ras_count !== 3'd0 || ras_err !== 1'b0) begin
      errors++;
      $display("FAIL ret: pc=%h cnt=%0d err=%b, expected pc=0011 cnt=0 err=0", pc, ras_count, ras_err);
    end
    idle();
  endtask

  task automatic test_nested();
    logic [15:0] call_pc [5] = '{16'h0110, 16'h0120, 16'h0130, 16'h0140, 16'h0150};
    logic [15:0] ret_pc  [4] = '{16'h0141, 16'h0131, 16'h0121, 16'h0111};
    go_to(16'h0100);
    for (int i = 0; i < 5; i++) begin
      jmp = 1; call = 1; jmpcond = C_AL; offset = 16'h0010;
      tick();
      checks++;
      if (pc !== call_pc[i] || ras_count !== ((i < 4) ? 3'(i + 1) : 3'd4) || ras_err !== (i == 4)) begin
        errors++;
        $display("FAIL nest_call[%0d]: pc=%h cnt=%0d err=%b, expected pc=%h cnt=%0d err=%b",
                 i, pc, ras_count, ras_err, call_pc[i], (i < 4) ? i + 1 : 4, i == 4);
      end
    end
    checks++;
    if (ras_full !== 1'b1 || ras_empty !== 1'b0) begin
      errors++;
      $display("FAIL nest_full: full=%b empty=%b, expected full=1 empty=0", ras_full, ras_empty);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      jmp = 1; jmpcond = C_RET; call = 1;
      tick();
      checks++;
      if (pc !== ret_pc[i] || ras_count !== 3'(3 - i)) begin
        errors++;
        $display("FAIL nest_ret[%0d]: pc=%h cnt=%0d, expected pc=%h cnt=%0d", i, pc, ras_count, ret_pc[i], 3 - i);
      end
    end
    jmp = 1; jmpcond = C_RET; call = 0; ra = 16'h0ABC;
    tick();
    checks++;
    if (pc !== 16'h0ABC || ras_count !== 3'd0 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL ret_empty: pc=%h cnt=%0d err=%b empty=%b, expected pc=0abc cnt=0 err=1 empty=1",
               pc, ras_count, ras_err, ras_empty);
    end
    idle();
  endtask

  task automatic test_jump();
    go_to(16'h0005);
    jmp = 1; jmpcond = C_EQ; flagz = 0; offset = 16'h0100;
    tick();
    checks++;
    if (pc !== 16'h0006) begin
      errors++;
      $display("FAIL jump_false: pc=%h expected 0006", pc);
    end
    jmp = 1; jmpcond = C_EQ; flagz = 1; offset = 16'h0100;
    tick();
    checks++;
    if (pc !== 16'h0106) begin
      errors++;
      $display("FAIL jump_true: pc=%h expected 0106", pc);
    end
    idle(); jmp = 1; call = 1; jmpcond = C_NV; offset = 16'h0100;
    tick();
    checks++;
    if (pc !== 16'h0107 || ras_count !== 3'd0) begin
      errors++;
      $display("FAIL call_false: pc=%h cnt=%0d, expected pc=0107 cnt=0", pc, ras_count);
    end
    idle();
  endtask

  task automatic test_stall();
    go_to(16'h0200);
    jmp = 1; call = 1; jmpcond = C_AL; offset = 16'h0010;
    tick();
    stall = 1;
    #1;
    checks++;
    if (pcnext !== 16'h0220) begin
      errors++;
      $display("FAIL stall_pcnext: got %h expected 0220", pcnext);
    end
    tick();
    checks++;
    if (pc !== 16'h0210 || ras_count !== 3'd1) begin
      errors++;
      $display("FAIL stall_call: pc=%h cnt=%0d, expected pc=0210 cnt=1", pc, ras_count);
    end
    jmpcond = C_RET; call = 0;
    tick();
    checks++;
    if (pc !== 16'h0210 || ras_count !== 3'd1) begin
      errors++;
      $display("FAIL stall_ret: pc=%h cnt=%0d, expected pc=0210 cnt=1", pc, ras_count);
    end
    jmpcond = C_AL; call = 1; redirect = 1; redirect_pc = 16'h8000;
    tick();
    checks++;
    if (pc !== 16'h8000 || ras_count !== 3'd1) begin
      errors++;
      $display("FAIL stall_redirect: pc=%h cnt=%0d, expected pc=8000 cnt=1", pc, ras_count);
    end
    idle();
  endtask

  task automatic test_wrap();
    go_to(16'hFFFF);
    tick();
    checks++;
    if (pc !== 16'h0000 || ras_err !== 1'b1) begin
      errors++;
      $display("FAIL wrap_seq: pc=%h err=%b, expected pc=0000 err=1", pc, ras_err);
    end
    go_to(16'h0020);
    jmp = 1; jmpcond = C_AL; offset = 16'hFFF0;
    tick();
    checks++;
    if (pc !== 16'h0010) begin
      errors++;
      $display("FAIL wrap_neg_offset: pc=%h expected 0010", pc);
    end
    idle();
    #3 rst_n = 0;
    #1;
    checks++;
    if (pc !== 16'h0000 || ras_count !== 3'd0 || ras_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: pc=%h cnt=%0d err=%b, expected pc=0000 cnt=0 err=0", pc, ras_count, ras_err);
    end
    #2 rst_n = 1;
    tick();
    checks++;
    if (pc !== 16'h0001) begin
      errors++;
      $display("FAIL post_reset: pc=%h expected 0001", pc);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_call_ret();
    test_nested();
    test_jump();
    test_stall();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
